// File: rtl/di_reg_terminal.sv
// di_reg_terminal: endpoint-selected register file with wait-state handshake.
// Optional burst pointer auto-increment: define DI_REG_TERMINAL_AUTOINC_EN.
module di_reg_terminal #(
  parameter logic [15:0] EP_ADDR     = 16'h0001,
  parameter int          NUM_REGS    = 16,
  parameter int          WAIT_CYCLES = 2,
  localparam int         IW          = $clog2(NUM_REGS)
) (
  input  logic                  if_clock,
  input  logic                  resetb,
  input  logic [15:0]           diEpAddr,
  input  logic [15:0]           diRegAddr,
  input  logic [15:0]           diRegDataIn,
  input  logic                  diWrite,
  input  logic                  diRead,
  input  logic                  diReset,
  output logic [15:0]           diRegDataOut,
  output logic                  rdwr_ready,
  output logic [16*NUM_REGS-1:0] regs_out,
  output logic                  wr_pulse,
  output logic [IW-1:0]         wr_index
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [15:0]   addr_q, addr_d;
  logic [15:0]   regs_q [NUM_REGS];
  logic [15:0]   regs_d [NUM_REGS];
  logic [15:0]   dout_q, dout_d;
  logic          wrp_q, wrp_d;
  logic [IW-1:0] wri_q, wri_d;

  logic sel;
  logic req;
  logic in_range;

  assign sel      = (diEpAddr == EP_ADDR);
  assign req      = sel & (diWrite | diRead);
  assign in_range = (diRegAddr < 16'(NUM_REGS));

  // Next-state, access commit and pointer tracking
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    addr_d  = diRegAddr;
    regs_d  = regs_q;
    dout_d  = dout_q;
    wrp_d   = 1'b0;
    wri_d   = wri_q;

    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_WAIT;
          cnt_d   = 4'(WAIT_CYCLES);
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_d = S_IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_ACK;
          if (diWrite) begin
            if (in_range) begin
              regs_d[ptr_q] = diRegDataIn;
              wrp_d         = 1'b1;
              wri_d         = ptr_q;
            end
          end else begin
            dout_d = in_range ? regs_q[ptr_q] : 16'hDEAD;
          end
        end
      end
      S_ACK: begin
        if (req) begin
          state_d = S_WAIT;
          cnt_d   = 4'(WAIT_CYCLES);
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A new address always wins over the burst step
    if (diRegAddr != addr_q) begin
      ptr_d = diRegAddr[IW-1:0];
    end
`ifdef DI_REG_TERMINAL_AUTOINC_EN
    else if (state_q == S_ACK) begin
      ptr_d = ptr_q + IW'(1);
    end
`else
`endif

    // Soft clear: drop any access, keep read data and last write index
    if (diReset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_d[i] = '0;
      ptr_d   = '0;
      cnt_d   = '0;
      state_d = S_IDLE;
      wrp_d   = 1'b0;
      dout_d  = dout_q;
      wri_d   = wri_q;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge if_clock) begin
    if (!resetb) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      dout_q  <= '0;
      wrp_q   <= 1'b0;
      wri_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      regs_q  <= regs_d;
      dout_q  <= dout_d;
      wrp_q   <= wrp_d;
      wri_q   <= wri_d;
    end
  end

  // Flatten register file onto the output bus
  always_comb begin
    regs_out = '0;
    for (int i = 0; i < NUM_REGS; i++) regs_out[16*i +: 16] = regs_q[i];
  end

  assign rdwr_ready   = (state_q != S_WAIT);
  assign diRegDataOut = dout_q;
  assign wr_pulse     = wrp_q;
  assign wr_index     = wri_q;

endmodule

// File: tb/tb_di_reg_terminal.sv
// tb_di_reg_terminal: directed scenarios plus random traffic
// checked every cycle against a transaction-level model.
module tb_di_reg_terminal;

`ifdef DI_REG_TERMINAL_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif
  localparam int WC = 2;

  logic         clk = 1'b0;
  logic         resetb = 1'b0;
  logic [15:0]  diEpAddr = '0;
  logic [15:0]  diRegAddr = '0;
  logic [15:0]  diRegDataIn = '0;
  logic         diWrite = 1'b0;
  logic         diRead = 1'b0;
  logic         diReset = 1'b0;
  logic [15:0]  diRegDataOut;
  logic         rdwr_ready;
  logic [255:0] regs_out;
  logic         wr_pulse;
  logic [3:0]   wr_index;

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  di_reg_terminal dut (
    .if_clock    (clk),
    .resetb      (resetb),
    .diEpAddr    (diEpAddr),
    .diRegAddr   (diRegAddr),
    .diRegDataIn (diRegDataIn),
    .diWrite     (diWrite),
    .diRead      (diRead),
    .diReset     (diReset),
    .diRegDataOut(diRegDataOut),
    .rdwr_ready  (rdwr_ready),
    .regs_out    (regs_out),
    .wr_pulse    (wr_pulse),
    .wr_index    (wr_index)
  );

  // Transaction model: m_busy = wait cycles left before commit (-1 = not waiting)
  logic [15:0] m_regs [16];
  int          m_busy = -1;
  bit          m_ack = 1'b0;
  bit          m_old_ack;
  int          m_ptr = 0;
  logic [15:0] m_prev = '0;
  logic [15:0] m_dout = '0;
  bit          m_wrp = 1'b0;
  logic [3:0]  m_wri = '0;
  bit          m_req;
  bit          m_commit;

  function automatic logic [255:0] m_flat();
    logic [255:0] f;
    for (int i = 0; i < 16; i++) f[16*i +: 16] = m_regs[i];
    return f;
  endfunction

  always @(posedge clk) begin
    m_req = (diEpAddr == 16'h0001) && (diWrite || diRead);
    if (!resetb) begin
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
      m_busy = -1; m_ack = 0; m_ptr = 0; m_prev = '0;
      m_dout = '0; m_wrp = 0; m_wri = '0;
    end else begin
      m_old_ack = m_ack;
      m_ack = 0;
      m_wrp = 0;
      m_commit = 0;
      if (diReset) begin
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_busy = -1;
      end else if (m_busy >= 0) begin
        if (!m_req) m_busy = -1;
        else if (m_busy > 0) m_busy--;
        else begin m_commit = 1; m_busy = -1; m_ack = 1; end
      end else if (m_req) begin
        m_busy = WC;
      end
      if (m_commit) begin
        if (diWrite) begin
          if (diRegAddr < 16) begin
            m_regs[m_ptr] = diRegDataIn;
            m_wrp = 1;
            m_wri = 4'(m_ptr);
          end
        end else begin
          m_dout = (diRegAddr < 16) ? m_regs[m_ptr] : 16'hDEAD;
        end
      end
      if (diReset) m_ptr = 0;
      else if (diRegAddr != m_prev) m_ptr = int'(diRegAddr) % 16;
      else if (m_old_ack && AUTOINC) m_ptr = (m_ptr + 1) % 16;
      m_prev = diRegAddr;
    end
  end

  task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Per-cycle comparison against the model
  always @(posedge clk) begin
    #1;
    if (chk_on) begin
      chk("ready", 256'(rdwr_ready), 256'(m_busy < 0));
      chk("dout", 256'(diRegDataOut), 256'(m_dout));
      chk("wr_pulse", 256'(wr_pulse), 256'(m_wrp));
      chk("wr_index", 256'(wr_index), 256'(m_wri));
      chk("regs_out", regs_out, m_flat());
    end
  end

  task automatic access(input logic [15:0] ep, a, d, input bit w, r,
                        output int lows);
    bit done;
    done = 0;
    lows = 0;
    @(negedge clk);
    diEpAddr = ep; diRegAddr = a; diRegDataIn = d; diWrite = w; diRead = r;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk); #1;
      if (!rdwr_ready) lows++;
      else done = 1;
    end
    if (!done) begin
      n_chk++; n_err++;
      $display("FAIL access_timeout: got ready=0 required ready=1");
    end
  endtask

  task automatic idle();
    @(negedge clk);
    diWrite = 0; diRead = 0; diEpAddr = 16'h0001;
  endtask

  initial begin
    int lows;
    int got;
    logic [15:0] vals [3];
    logic [15:0] exp_b [3];

    repeat (2) @(posedge clk);
    #1;
    chk_on = 1;
    chk("rst_ready", 256'(rdwr_ready), 256'(1));
    chk("rst_dout", 256'(diRegDataOut), 256'(0));
    chk("rst_regs", regs_out, 256'(0));
    chk("rst_wrp", 256'(wr_pulse), 256'(0));
    chk("rst_wri", 256'(wr_index), 256'(0));
    @(negedge clk); resetb = 1;

    access(16'h0001, 16'd3, 16'hA5A5, 1, 0, lows);
    chk("w3_lows", 256'(lows), 256'(3));
    chk("w3_pulse", 256'(wr_pulse), 256'(1));
    chk("w3_index", 256'(wr_index), 256'(3));
    chk("w3_reg", 256'(regs_out[63:48]), 256'(16'hA5A5));
    idle();

    access(16'h0002, 16'd3, 16'h1234, 1, 0, lows);
    chk("ep2_lows", 256'(lows), 256'(0));
    chk("ep2_pulse", 256'(wr_pulse), 256'(0));
    chk("ep2_reg", 256'(regs_out[63:48]), 256'(16'hA5A5));
    idle();

    @(negedge clk);
    diRegAddr = 16'd5; diRegDataIn = 16'hBEEF; diWrite = 1;
    @(posedge clk); #1;
    chk("ab_wait", 256'(rdwr_ready), 256'(0));
    @(negedge clk); diEpAddr = 16'h0002;
    @(posedge clk); #1;
    chk("ab_ready", 256'(rdwr_ready), 256'(1));
    repeat (4) @(posedge clk);
    #1;
    chk("ab_reg5", 256'(regs_out[95:80]), 256'(0));
    idle();

    access(16'h0001, 16'd20, 16'h0, 0, 1, lows);
    chk("oor_read", 256'(diRegDataOut), 256'(16'hDEAD));
    idle();
    access(16'h0001, 16'd20, 16'h7777, 1, 0, lows);
    chk("oor_wrp", 256'(wr_pulse), 256'(0));
    idle();

    access(16'h0001, 16'd14, 16'h1114, 1, 0, lows); idle();
    access(16'h0001, 16'd15, 16'h1115, 1, 0, lows); idle();
    access(16'h0001, 16'd0, 16'h1100, 1, 0, lows); idle();
    exp_b[0] = 16'h1114;
    exp_b[1] = AUTOINC ? 16'h1115 : 16'h1114;
    exp_b[2] = AUTOINC ? 16'h1100 : 16'h1114;
    @(negedge clk);
    diRegAddr = 16'd14; diRead = 1;
    got = 0;
    for (int i = 0; i < 60 && got < 3; i++) begin
      @(posedge clk); #1;
      if (rdwr_ready) begin vals[got] = diRegDataOut; got++; end
    end
    chk("burst_cnt", 256'(got), 256'(3));
    for (int i = 0; i < got; i++) chk("burst_val", 256'(vals[i]), 256'(exp_b[i]));
    idle();

    @(negedge clk); diReset = 1;
    @(negedge clk); diReset = 0;
    chk("srst_regs", regs_out, 256'(0));
    chk("srst_dout", 256'(diRegDataOut), 256'(exp_b[2]));
    access(16'h0001, 16'd14, 16'h4242, 1, 0, lows);
    chk("srst_ptr", 256'(wr_index), 256'(0));
    chk("srst_reg0", 256'(regs_out[15:0]), 256'(16'h4242));
    idle();

    @(negedge clk);
    diRegAddr = 16'd2; diRegDataIn = 16'h1111; diWrite = 1;
    repeat (2) @(posedge clk);
    @(negedge clk); resetb = 0;
    @(posedge clk); #1;
    chk("hr_ready", 256'(rdwr_ready), 256'(1));
    chk("hr_dout", 256'(diRegDataOut), 256'(0));
    chk("hr_regs", regs_out, 256'(0));
    chk("hr_wrp", 256'(wr_pulse), 256'(0));
    chk("hr_wri", 256'(wr_index), 256'(0));
    @(negedge clk); resetb = 1; diWrite = 0;

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom % 16 == 0) diEpAddr = ($urandom % 4 == 0) ? 16'h0002 : 16'h0001;
      if ($urandom % 12 == 0) diRegAddr = 16'($urandom % 20);
      diRegDataIn = 16'($urandom);
      if ($urandom % 6 == 0) diWrite = ~diWrite;
      if ($urandom % 6 == 0) diRead = ~diRead;
      diReset = ($urandom % 120 == 0);
      resetb = ($urandom % 300 != 0);
    end
    @(negedge clk);
    resetb = 1; diReset = 0; diWrite = 0; diRead = 0;
    repeat (3) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
